// File: rtl/demux_tdm_pkg.sv
// demux_tdm_pkg: shared types and constants for the 1-to-4 TDM demultiplexer.
// Holds the HUNT/LOCKED state enum, the slot count and the 2-bit slot index type.
package demux_tdm_pkg;
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;
    localparam int NUM_SLOTS = 4;
    typedef logic [1:0] slot_t;
    localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);
endpackage

// File: rtl/demux_1to4_tdm_if.sv
// demux_1to4_tdm_if: TDM sample input and frame output bundle.
// master: drives din/din_valid/frame_sync and observes the results.
// slave : the demultiplexer; receives samples and drives dout, frame_valid, slot,
//         locked, sync_err and frame_cnt.
interface demux_1to4_tdm_if #(
    parameter int WIDTH = 1
);
    import demux_tdm_pkg::*;
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               frame_sync;
    logic [4*WIDTH-1:0] dout;
    logic               frame_valid;
    slot_t              slot;
    logic               locked;
    logic               sync_err;
    logic [7:0]         frame_cnt;
    modport master (
        output din, din_valid, frame_sync,
        input  dout, frame_valid, slot, locked, sync_err, frame_cnt
    );
    modport slave (
        input  din, din_valid, frame_sync,
        output dout, frame_valid, slot, locked, sync_err, frame_cnt
    );
endinterface

// File: rtl/tdm_slot_fsm.sv
// tdm_slot_fsm: HUNT/LOCKED framing FSM and slot counter for the TDM demux.
// Ports: clk, rst_n (async, active-low); beat (din_valid), frame_sync in;
//        slot, locked, sync_err registered out; wr_en/wr_lane tell the datapath
//        which shadow lane takes din this cycle; frame_done marks the slot-3 beat.
module tdm_slot_fsm
    import demux_tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  beat,
    input  logic  frame_sync,
    output slot_t slot,
    output logic  locked,
    output logic  sync_err,
    output logic  wr_en,
    output slot_t wr_lane,
    output logic  frame_done
);
    state_t state_q, state_d;
    slot_t  slot_q, slot_d;
    logic   sync_err_q, sync_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            slot_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        sync_err_d = 1'b0;
        wr_en      = 1'b0;
        wr_lane    = slot_q;
        frame_done = 1'b0;
        if (beat) begin
            if (frame_sync) begin
                // A sync beat always restarts at lane 0; it is only an error
                // when it cuts a locked frame short.
                sync_err_d = (state_q == LOCKED) && (slot_q != '0);
                state_d    = LOCKED;
                slot_d     = slot_t'(1);
                wr_en      = 1'b1;
                wr_lane    = '0;
            end else if (state_q == LOCKED) begin
                if (slot_q == '0) begin
                    sync_err_d = 1'b1;
                    state_d    = HUNT;
                end else begin
                    wr_en      = 1'b1;
                    frame_done = slot_q == LAST_SLOT;
                    slot_d     = slot_q + 1'b1;
                end
            end
        end
    end

    assign slot     = slot_q;
    assign locked   = state_q == LOCKED;
    assign sync_err = sync_err_q;
endmodule

// File: rtl/demux_1to4_tdm.sv
// demux_1to4_tdm: 1-to-4 TDM demultiplexer with frame-sync lock tracking.
// Ports: clk, rst_n (async, active-low), bus (demux_1to4_tdm_if.slave) carrying
//        din/din_valid/frame_sync in and dout/frame_valid/slot/locked/sync_err/
//        frame_cnt out. Lanes 0..2 collect in shadow registers; dout is loaded
//        with all four lanes at once on the slot-3 beat.
module demux_1to4_tdm
    import demux_tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    demux_1to4_tdm_if.slave   bus
);
    logic [WIDTH-1:0]   shadow_q [NUM_SLOTS-1];
    logic [WIDTH-1:0]   shadow_d [NUM_SLOTS-1];
    logic [4*WIDTH-1:0] dout_q, dout_d;
    logic               frame_valid_q, frame_valid_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               wr_en, frame_done;
    slot_t              wr_lane;

    tdm_slot_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat       (bus.din_valid),
        .frame_sync (bus.frame_sync),
        .slot       (bus.slot),
        .locked     (bus.locked),
        .sync_err   (bus.sync_err),
        .wr_en      (wr_en),
        .wr_lane    (wr_lane),
        .frame_done (frame_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '{default: '0};
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_SLOTS - 1; i++)
            if (wr_en && wr_lane == slot_t'(i)) shadow_d[i] = bus.din;
        // The slot-3 sample bypasses the shadow straight into dout.
        dout_d        = frame_done ? {bus.din, shadow_q[2], shadow_q[1], shadow_q[0]} : dout_q;
        frame_valid_d = frame_done;
        frame_cnt_d   = frame_done ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    assign bus.dout        = dout_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_demux_1to4_tdm.sv
// tb_demux_1to4_tdm: directed self-checking bench for demux_1to4_tdm (WIDTH=1).
module tb_demux_1to4_tdm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_cnt = '0;

    demux_1to4_tdm_if #(.WIDTH(1)) bus ();
    demux_1to4_tdm #(.WIDTH(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".dout"}, 32'(bus.dout), 32'h0);
        check({tag, ".fv"}, 32'(bus.frame_valid), 32'h0);
        check({tag, ".slot"}, 32'(bus.slot), 32'h0);
        check({tag, ".locked"}, 32'(bus.locked), 32'h0);
        check({tag, ".serr"}, 32'(bus.sync_err), 32'h0);
        check({tag, ".cnt"}, 32'(bus.frame_cnt), 32'h0);
    endtask

    task automatic beat(input logic d, input logic fs);
        @(negedge clk);
        bus.din = d;
        bus.frame_sync = fs;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.frame_sync = 1'b0;
        bus.din = 1'b0;
    endtask

    // Idle cycles carry frame_sync/din noise that must be ignored.
    task automatic idle(input int n);
        bus.din = 1'b1;
        bus.frame_sync = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        bus.frame_sync = 1'b0;
        bus.din = 1'b0;
    endtask

    task automatic frame(input logic [3:0] v);
        beat(v[0], 1'b1);
        beat(v[1], 1'b0);
        beat(v[2], 1'b0);
        beat(v[3], 1'b0);
        exp_cnt++;
    endtask

    initial begin
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.frame_sync = 1'b0;
        #3;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        beat(1'b1, 1'b1);
        check("first.slot", 32'(bus.slot), 32'h1);
        check("first.locked", 32'(bus.locked), 32'h1);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        exp_cnt = 8'd1;
        check("first.dout", 32'(bus.dout), 32'hD);
        check("first.fv", 32'(bus.frame_valid), 32'h1);
        check("first.cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
        check("first.slot0", 32'(bus.slot), 32'h0);
        idle(1);
        check("first.fv_pulse", 32'(bus.frame_valid), 32'h0);
        check("first.hold", 32'(bus.dout), 32'hD);

        frame(4'hA);
        check("b2b.doutA", 32'(bus.dout), 32'hA);
        check("b2b.fvA", 32'(bus.frame_valid), 32'h1);
        beat(1'b1, 1'b1);
        check("b2b.fv_drop", 32'(bus.frame_valid), 32'h0);
        check("b2b.holdA", 32'(bus.dout), 32'hA);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        exp_cnt++;
        check("b2b.dout5", 32'(bus.dout), 32'h5);
        check("b2b.fv5", 32'(bus.frame_valid), 32'h1);
        check("b2b.cnt", 32'(bus.frame_cnt), 32'(exp_cnt));

        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        check("early.serr", 32'(bus.sync_err), 32'h1);
        check("early.slot", 32'(bus.slot), 32'h1);
        check("early.locked", 32'(bus.locked), 32'h1);
        check("early.fv", 32'(bus.frame_valid), 32'h0);
        check("early.hold", 32'(bus.dout), 32'h5);
        idle(1);
        check("early.serr_pulse", 32'(bus.sync_err), 32'h0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        exp_cnt++;
        check("early.dout", 32'(bus.dout), 32'h6);
        check("early.cnt", 32'(bus.frame_cnt), 32'(exp_cnt));

        beat(1'b1, 1'b0);
        check("miss.serr", 32'(bus.sync_err), 32'h1);
        check("miss.locked", 32'(bus.locked), 32'h0);
        check("miss.slot", 32'(bus.slot), 32'h0);
        idle(1);
        check("miss.serr_pulse", 32'(bus.sync_err), 32'h0);
        for (int i = 0; i < 4; i++) beat(1'b1, 1'b0);
        check("hunt.locked", 32'(bus.locked), 32'h0);
        check("hunt.slot", 32'(bus.slot), 32'h0);
        check("hunt.serr", 32'(bus.sync_err), 32'h0);
        check("hunt.hold", 32'(bus.dout), 32'h6);
        check("hunt.cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
        frame(4'h9);
        check("relock.dout", 32'(bus.dout), 32'h9);

        beat(1'b0, 1'b1);
        idle(5);
        check("gap.fv0", 32'(bus.frame_valid), 32'h0);
        check("gap.locked", 32'(bus.locked), 32'h1);
        beat(1'b0, 1'b0);
        idle(0);
        beat(1'b1, 1'b0);
        idle(3);
        check("gap.slot", 32'(bus.slot), 32'h3);
        check("gap.serr", 32'(bus.sync_err), 32'h0);
        beat(1'b1, 1'b0);
        exp_cnt++;
        check("gap.dout", 32'(bus.dout), 32'hC);
        check("gap.fv", 32'(bus.frame_valid), 32'h1);
        idle(4);
        check("gap.fv_after", 32'(bus.frame_valid), 32'h0);
        check("gap.cnt", 32'(bus.frame_cnt), 32'(exp_cnt));

        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check("rst.fv", 32'(bus.frame_valid), 32'h0);
        #2 rst_n = 1'b1;
        exp_cnt = '0;
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        check("rst.needsync", 32'(bus.locked), 32'h0);
        check("rst.cnt", 32'(bus.frame_cnt), 32'h0);

        for (int i = 0; i < 255; i++) frame(4'(i));
        check("wrap.cnt255", 32'(bus.frame_cnt), 32'(exp_cnt));
        frame(4'h3);
        check("wrap.cnt0", 32'(bus.frame_cnt), 32'h0);
        check("wrap.dout", 32'(bus.dout), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/demux_1to4_tdm.md
DEMUX_1TO4_TDM -- requirements
Module: demux_1to4_tdm

Interface
REQ-001 SHALL provide parameter WIDTH, default 1, defining the bit width of one slot sample.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port din  input  WIDTH  serial TDM sample for the current slot.
REQ-005 SHALL provide port din_valid  input  1  din carries a sample this cycle (one beat).
REQ-006 SHALL provide port frame_sync  input  1  qualified by din_valid; marks the beat as slot 0.
REQ-007 SHALL provide port dout  output  4*WIDTH  last complete frame; lane k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL provide port frame_valid  output  1  one-cycle pulse when dout is updated.
REQ-009 SHALL provide port slot  output  2  index of the next expected slot.
REQ-010 SHALL provide port locked  output  1  high in LOCKED state.
REQ-011 SHALL provide port sync_err  output  1  one-cycle pulse on a framing violation.
REQ-012 SHALL provide port frame_cnt  output  8  count of completed frames, wrapping 255->0.

Function
REQ-013 SHALL implement the two-state FSM HUNT and LOCKED.
REQ-014 SHALL, in HUNT, discard beats with frame_sync=0 without asserting sync_err.
REQ-015 SHALL, in HUNT, on a beat with frame_sync=1: store din in shadow lane 0, set slot=1 and enter LOCKED.
REQ-016 SHALL, in LOCKED, store each beat's din in shadow lane slot and increment slot modulo 4.
REQ-017 SHALL, on the slot-3 beat, load dout with {din, shadow[2], shadow[1], shadow[0]} at that rising edge (all four lanes atomically), pulse frame_valid for exactly the following cycle, increment frame_cnt and set slot=0.
REQ-018 SHALL hold dout stable between frame_valid pulses; partial frames never reach dout.
REQ-019 SHALL make no state change on cycles with din_valid=0; frame_sync is ignored on those cycles.
REQ-020 SHALL treat frame_sync=1 on a beat with slot!=0 in LOCKED as an early sync: pulse sync_err, discard the partial frame, store din in lane 0, set slot=1 and stay LOCKED.
REQ-021 SHALL treat frame_sync=0 on a beat with slot=0 in LOCKED as a missing sync: pulse sync_err, discard the beat and enter HUNT with slot=0.
REQ-022 SHALL tolerate back-to-back beats (din_valid held high) with no bubble between frames; the slot-3 beat and the next frame's slot-0 beat on consecutive cycles both complete normally.
REQ-023 SHALL drive frame_valid, sync_err, slot, locked and frame_cnt directly from registers.

Reset
REQ-024 SHALL, while rst_n=0, force state=HUNT, slot=0, dout=0, shadow=0, frame_valid=0, sync_err=0, locked=0 and frame_cnt=0, independent of clk.
REQ-025 SHALL, on reset mid-frame, discard the partial frame, emit no frame_valid, and require a fresh frame_sync after release.
REQ-026 SHALL accept a beat on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place the FSM state enum (HUNT, LOCKED), NUM_SLOTS=4 and the 2-bit slot type in package demux_tdm_pkg.
REQ-028 SHALL split the HUNT/LOCKED FSM and slot counter into one sub-module, tdm_slot_fsm; datapath registers stay in demux_1to4_tdm.

Verification
REQ-029 Reset release, then beats 1,0,1,1 (WIDTH=1) with frame_sync on the first beat -> dout=4'b1101 and frame_valid high one cycle, frame_cnt=1.
REQ-030 Two back-to-back frames 4'hA then 4'h5 (LSB-first slots), din_valid held high -> frame_valid pulses on consecutive frame boundaries, dout=4'hA then 4'h5, frame_cnt=2.
REQ-031 frame_sync asserted on the slot-2 beat -> sync_err pulses once, the partial frame is never output, and the next three beats complete a frame.
REQ-032 Slot-0 beat without frame_sync while LOCKED -> sync_err pulses, locked falls, and beats are ignored until the next frame_sync.
REQ-033 din_valid gaps of 0-5 cycles between beats -> dout equals a gapless run with the same data, and no extra pulses occur.
REQ-034 rst_n pulsed low after the slot-1 beat -> all outputs are 0 immediately with no frame_valid; 256 complete frames -> frame_cnt wraps to 0.
